// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared constants, fetch-state enum and 16-bit ripple adder for the prefetch unit
//
// Contents:
//   NOP_INST       - instruction presented to decode when no real instruction is available
//   fetch_state_e  - fetch FSM states (IDLE, WAIT, DROP)
//   ripple_add16   - 16-bit ripple-carry adder used for PC increments when ADDR_W = 16

package if_pkg;

  localparam logic [15:0] NOP_INST = 16'h0800;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // free to issue a request
    WAIT = 2'd1,  // one request outstanding, response will be pushed
    DROP = 2'd2   // one request outstanding, response must be discarded
  } fetch_state_e;

  function automatic logic [15:0] ripple_add16(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] s;
    logic        c;
    c = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return s;
  endfunction

endpackage

// File: rtl/if_queue.sv
// rtl/if_queue.sv - power-of-two FIFO with flush, used as the instruction queue
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (pointers and count only)
//   flush       - empty the queue; overrides push and pop in the same cycle
//   push        - write push_data at the tail (caller guarantees not full)
//   push_data   - entry to write
//   pop         - drop the head entry (caller guarantees not empty)
//   head_data   - current head entry (meaningless when count = 0)
//   count       - number of entries held, 0..DEPTH

module if_queue #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [PW:0]  count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage is not reset so it can map onto plain registers/RAM.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - instruction prefetch unit: single-outstanding fetch FSM feeding an instruction queue
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   imem_req/imem_addr  - instruction-memory read request and address (fetch PC)
//   imem_gnt            - request accepted this cycle
//   imem_rvalid/rdata   - read response
//   redirect/_pc        - taken branch/jump: flush queue, restart fetch at redirect_pc
//   stall               - hold the presented instruction (no pop)
//   halt_n              - low blocks new requests only
//   inst/pc_plus2       - instruction to decode and its PC + 2
//   inst_valid          - inst is a real fetched instruction

module if_prefetch
  import if_pkg::*;
#(
  parameter int                 DATA_W   = 16,
  parameter int                 ADDR_W   = 16,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  input  logic              halt_n,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] pc_plus2,
  output logic              inst_valid
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e             state;
  logic [ADDR_W-1:0]        fetch_pc;
  logic [ADDR_W-1:0]        issue_pc;
  logic [CW-1:0]            count;
  logic [DATA_W+ADDR_W-1:0] head;
  logic [DATA_W-1:0]        head_inst;
  logic [ADDR_W-1:0]        head_pc;
  logic [ADDR_W-1:0]        fetch_pc_inc;
  logic [ADDR_W-1:0]        head_pc_inc;
  logic                     fire;
  logic                     push;
  logic                     pop;

  assign {head_inst, head_pc} = head;

  if (ADDR_W == 16) begin : g_ripple
    assign fetch_pc_inc = ripple_add16(fetch_pc, 16'd2);
    assign head_pc_inc  = ripple_add16(head_pc, 16'd2);
  end else begin : g_generic
    assign fetch_pc_inc = fetch_pc + ADDR_W'(2);
    assign head_pc_inc  = head_pc + ADDR_W'(2);
  end

  // A pop in the same cycle is not credited: the request needs a free slot now,
  // which also guarantees the eventual push never hits a full queue.
  assign imem_req  = rst_n && (state == IDLE) && halt_n && !redirect && (count < CW'(DEPTH));
  assign imem_addr = fetch_pc;
  assign fire      = imem_req && imem_gnt;

  // Responses are only accepted in WAIT; IDLE and DROP ignore stray rvalid.
  assign push = (state == WAIT) && imem_rvalid && !redirect;

  assign inst_valid = (count != '0) && !redirect;
  assign pop        = inst_valid && !stall;
  assign inst       = inst_valid ? head_inst : DATA_W'(NOP_INST);
  assign pc_plus2   = inst_valid ? head_pc_inc : fetch_pc_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      issue_pc <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (fire) begin
            state    <= WAIT;
            issue_pc <= fetch_pc;
          end
        end
        WAIT: begin
          // rvalid with redirect is discarded (push is gated) and still returns to IDLE.
          if (imem_rvalid)   state <= IDLE;
          else if (redirect) state <= DROP;
        end
        DROP: begin
          if (imem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (redirect)  fetch_pc <= redirect_pc;
      else if (fire) fetch_pc <= fetch_pc_inc;
    end
  end

  if_queue #(
    .W     (DATA_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (push),
    .push_data ({imem_rdata, issue_pc}),
    .pop       (pop),
    .head_data (head),
    .count     (count)
  );

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 The block SHALL have parameter DATA_W, 16, instruction width.
REQ-002 The block SHALL have parameter ADDR_W, 16, PC width.
REQ-003 The block SHALL have parameter DEPTH, 4, instruction queue entries (power of 2, >= 2).
REQ-004 The block SHALL have parameter RESET_PC, 0, fetch PC after reset.
REQ-005 The block SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-006 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have port imem_req  output  1  instruction-memory read request.
REQ-008 The block SHALL have port imem_addr  output  ADDR_W  request address.
REQ-009 The block SHALL have port imem_gnt  input  1  request accepted this cycle.
REQ-010 The block SHALL have port imem_rvalid  input  1  read data valid.
REQ-011 The block SHALL have port imem_rdata  input  DATA_W  read data.
REQ-012 The block SHALL have port redirect  input  1  taken branch/jump resolved downstream.
REQ-013 The block SHALL have port redirect_pc  input  ADDR_W  redirect target.
REQ-014 The block SHALL have port stall  input  1  decode hazard or data-memory stall; hold output.
REQ-015 The block SHALL have port halt_n  input  1  low = stop issuing fetches.
REQ-016 The block SHALL have port inst  output  DATA_W  instruction to decode.
REQ-017 The block SHALL have port pc_plus2  output  ADDR_W  PC of inst plus 2.
REQ-018 The block SHALL have port inst_valid  output  1  inst is a real fetched instruction.

Function
REQ-019 Queue SHALL hold {instruction, PC} entries; read/write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-020 Fetch FSM SHALL have states IDLE, WAIT, DROP.
REQ-021 IDLE: imem_req SHALL be 1 combinationally iff halt_n & ~redirect & (count + 1 <= DEPTH accounting for a pop this cycle is NOT credited); imem_addr SHALL equal fetch PC.
REQ-022 IDLE with imem_req & imem_gnt: fetch PC += 2 (mod 2^ADDR_W), next state WAIT.
REQ-023 imem_addr SHALL remain stable while imem_req is held without grant.
REQ-024 WAIT with imem_rvalid & ~redirect: push {imem_rdata, issued PC}, next state IDLE.
REQ-025 WAIT with redirect and no imem_rvalid: next state DROP; with imem_rvalid same cycle: data discarded, next IDLE.
REQ-026 DROP: imem_req SHALL be 0; on imem_rvalid data SHALL be discarded, next IDLE.
REQ-027 Redirect (any state): queue flushed, fetch PC <= redirect_pc next edge, inst_valid 0 that cycle.
REQ-028 Output: when count>0 & ~redirect, inst = head instruction, pc_plus2 = head PC + 2, inst_valid = 1; otherwise inst = NOP 0x0800 (zero-extended/truncated to DATA_W), pc_plus2 = fetch PC + 2, inst_valid = 0.
REQ-029 Pop SHALL occur iff inst_valid & ~stall; stall SHALL hold inst/pc_plus2 unchanged.
REQ-030 Simultaneous push and pop SHALL leave count unchanged; push SHALL never occur at count = DEPTH (guaranteed by REQ-021).
REQ-031 halt_n low SHALL not affect queue draining or an in-flight response; it only blocks new requests.
REQ-032 At most one request SHALL be outstanding.

Reset
REQ-033 rst_n low SHALL asynchronously set fetch PC = RESET_PC, count = 0, pointers = 0, state = IDLE.
REQ-034 During reset imem_req SHALL be 0, inst = NOP, inst_valid = 0; queue data contents need not be cleared.
REQ-035 A response arriving in the first cycle after reset release SHALL be ignored (state IDLE).

Structure
REQ-036 Shared package if_pkg SHALL hold the NOP encoding constant and the fetch-state enum.
REQ-037 The queue SHALL be a sub-module if_queue (parametrised FIFO with flush, push, pop, count).
REQ-038 PC increment SHALL reuse the existing 16-bit ripple adder when ADDR_W = 16.

Verification
REQ-039 Reset release, imem grants every cycle, rvalid 1 cycle after grant -> addresses 0x0000,0x0002,0x0004 requested; inst_valid rises, inst = data@0x0000, pc_plus2 = 0x0002.
REQ-040 stall held 10 cycles with DEPTH=4 -> exactly 4 entries queued, imem_req drops, inst unchanged; release -> 4 pops in order.
REQ-041 redirect to 0x0100 while WAIT, rvalid 2 cycles later with 0xDEAD -> 0xDEAD never output, next request addr 0x0100, queue empty.
REQ-042 redirect same cycle as rvalid -> data dropped, FSM IDLE next cycle, request 0x0100.
REQ-043 halt_n low with 2 queued -> both drained, then inst = 0x0800, inst_valid 0, no new requests.
REQ-044 fetch PC 0xFFFE granted -> next imem_addr 0x0000 (wrap); rst_n asserted mid-WAIT -> outputs reset immediately, imem_addr = RESET_PC.
